// File: rtl/tape_port_if.sv
// tape_port_if
//   Bundles every signal between the tape port arbiter, its two requesters
//   (port A = IM6100 IOT logic, port B = front-panel loader) and the SD tape
//   reader/punch emulator.
//
// Handshake: a requester raises <x>_req as a level together with a stable
//   <x>_op / <x>_wdata and holds them until it sees <x>_ack high for one
//   cycle. ack_err and rdata are only meaningful in that ack cycle. The tape
//   side answers each one-cycle strobe by dropping tape_punch_ready (accept)
//   and raising it again (done).
//
// Modports
//   slave  : the arbiter (drives acks, rdata, tape strobes, mount outputs)
//   master : the environment (requesters, mount control and tape emulator)
interface tape_port_if;
  logic        a_req, b_req;
  logic [1:0]  a_op, b_op;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [7:0]  rdata;
  logic        ack_err;
  logic        mount_req;
  logic [3:0]  mount_slot;
  logic        mount_busy;
  logic        tape_read, tape_punch, tape_flush, tape_rewind;
  logic [7:0]  tape_punch_data;
  logic [21:0] tape_start_block, tape_start_block_write;
  logic        tape_read_busy, tape_punch_ready;
  logic [7:0]  tape_read_data;
  logic        tape_eot;
  logic        eot, timeout_err;

  modport slave (
    input  a_req, b_req, a_op, b_op, a_wdata, b_wdata,
    input  mount_req, mount_slot,
    input  tape_read_busy, tape_punch_ready, tape_read_data, tape_eot,
    output a_ack, b_ack, rdata, ack_err, mount_busy,
    output tape_read, tape_punch, tape_flush, tape_rewind, tape_punch_data,
    output tape_start_block, tape_start_block_write, eot, timeout_err
  );

  modport master (
    output a_req, b_req, a_op, b_op, a_wdata, b_wdata,
    output mount_req, mount_slot,
    output tape_read_busy, tape_punch_ready, tape_read_data, tape_eot,
    input  a_ack, b_ack, rdata, ack_err, mount_busy,
    input  tape_read, tape_punch, tape_flush, tape_rewind, tape_punch_data,
    input  tape_start_block, tape_start_block_write, eot, timeout_err
  );
endinterface

// File: rtl/tape_port_arbiter.sv
// tape_port_arbiter
//   Shares the single SD tape channel between port A and port B with a
//   round-robin arbiter, turns each grant into one read/punch/flush strobe,
//   waits for the tape accept/ready handshake and acks the requester. Also
//   sequences virtual tape mounts: start-block update, flush of a dirty punch
//   buffer, then rewind.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   bus          : tape_port_if.slave (requesters, mount control, tape side)
//   dbg_state_o  : current FSM state encoding
//   dbg_flags_o  : {dirty, mount pending, rr prefers B, tape_read_busy reg}
module tape_port_arbiter #(
  parameter logic [21:0] SLOT_BLOCKS  = 22'd8192,
  parameter logic [21:0] WRITE_OFFSET = 22'd2097152,
  parameter int unsigned TIMEOUT_CYC  = 27_000_000
) (
  input  logic        clk,
  input  logic        reset,
  tape_port_if.slave  bus,
  output logic [2:0]  dbg_state_o,
  output logic [3:0]  dbg_flags_o
);
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACCEPT, S_WAIT_READY, S_M_FLUSH, S_M_WAIT, S_M_REWIND
  } state_t;

  localparam logic [31:0] TMR_LAST = 32'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic        rr_q, rr_d;          // 1: prefer B on a tie
  logic        gnt_q, gnt_d;        // 1: B owns the transaction
  logic [1:0]  op_q, op_d;
  logic [7:0]  pdata_q, pdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d, err_q, err_d;
  logic        dirty_q, dirty_d, pend_q, pend_d;
  logic [3:0]  slot_q, slot_d;
  logic [21:0] blk_q, blk_d, blkw_q, blkw_d;
  logic        rew_q, rew_d;
  logic        low_q, low_d;        // mount flush: tape has accepted
  logic [31:0] tmr_q, tmr_d;
  logic        tout_q, tout_d;
  logic        eot_q, rdbusy_q;

  logic        a_pend, b_pend, pick_b, tmr_hit;
  logic [1:0]  sel_op;
  logic [7:0]  sel_wd;
  logic [3:0]  slot_sel;
  logic [21:0] slot_blk;

  // A port whose ack is on the wire this cycle may still hold req; do not
  // re-grant it off that stale level.
  assign a_pend   = bus.a_req & ~a_ack_q;
  assign b_pend   = bus.b_req & ~b_ack_q;
  assign pick_b   = b_pend & (~a_pend | rr_q);
  assign sel_op   = pick_b ? bus.b_op : bus.a_op;
  assign sel_wd   = pick_b ? bus.b_wdata : bus.a_wdata;
  assign tmr_hit  = (tmr_q >= TMR_LAST);
  // A mount strobe arriving in IDLE is taken in the same cycle, so a request
  // raised alongside it cannot slip in ahead of the mount.
  assign slot_sel = bus.mount_req ? bus.mount_slot : slot_q;
  assign slot_blk = 22'({18'd0, slot_sel} * SLOT_BLOCKS);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    pdata_d = pdata_q;
    rdata_d = rdata_q;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    err_d   = 1'b0;
    dirty_d = dirty_q;
    pend_d  = pend_q;
    slot_d  = slot_q;
    blk_d   = blk_q;
    blkw_d  = blkw_q;
    rew_d   = 1'b0;
    low_d   = low_q;
    tmr_d   = tmr_q;
    tout_d  = tout_q;

    if (bus.mount_req) begin
      pend_d = 1'b1;
      slot_d = bus.mount_slot;
    end

    unique case (state_q)
      S_IDLE: begin
        // Nothing is started while the rewind strobe is out.
        if (rew_q) begin
          state_d = S_IDLE;
        end else if (pend_q || bus.mount_req) begin
          blk_d   = slot_blk;
          blkw_d  = slot_blk + WRITE_OFFSET;
          tmr_d   = '0;
          low_d   = 1'b0;
          state_d = dirty_q ? S_M_FLUSH : S_M_REWIND;
        end else if (bus.tape_punch_ready && (a_pend || b_pend)) begin
          gnt_d = pick_b;
          if (sel_op == 2'd3) begin
            a_ack_d = ~pick_b;
            b_ack_d = pick_b;
            err_d   = 1'b1;
            rr_d    = ~pick_b;
          end else begin
            op_d    = sel_op;
            if (sel_op == 2'd1) pdata_d = sel_wd;
            tmr_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT_ACCEPT;
      S_WAIT_ACCEPT, S_WAIT_READY: begin
        tmr_d = tmr_q + 32'd1;
        if (state_q == S_WAIT_ACCEPT && !bus.tape_punch_ready) begin
          state_d = S_WAIT_READY;
        end else if (state_q == S_WAIT_READY && bus.tape_punch_ready) begin
          if (op_q == 2'd0) rdata_d = bus.tape_read_data;
          if (op_q == 2'd1) dirty_d = 1'b1;
          if (op_q == 2'd2) dirty_d = 1'b0;
          a_ack_d = ~gnt_q;
          b_ack_d = gnt_q;
          rr_d    = ~gnt_q;
          state_d = S_IDLE;
        end else if (tmr_hit) begin
          tout_d  = 1'b1;
          a_ack_d = ~gnt_q;
          b_ack_d = gnt_q;
          err_d   = 1'b1;
          rr_d    = ~gnt_q;
          state_d = S_IDLE;
        end
      end
      S_M_FLUSH: state_d = S_M_WAIT;
      S_M_WAIT: begin
        tmr_d = tmr_q + 32'd1;
        if (low_q && bus.tape_punch_ready) begin
          dirty_d = 1'b0;
          state_d = S_M_REWIND;
        end else if (!low_q && !bus.tape_punch_ready) begin
          low_d = 1'b1;
        end else if (tmr_hit) begin
          // Mount stays pending and is retried from IDLE.
          tout_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_M_REWIND: begin
        rew_d   = 1'b1;
        dirty_d = 1'b0;
        pend_d  = bus.mount_req;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      op_q    <= 2'd0;
      pdata_q <= 8'd0;
      rdata_q <= 8'd0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      err_q   <= 1'b0;
      dirty_q <= 1'b0;
      pend_q  <= 1'b0;
      slot_q  <= 4'd0;
      blk_q   <= 22'd0;
      blkw_q  <= WRITE_OFFSET;
      rew_q   <= 1'b0;
      low_q   <= 1'b0;
      tmr_q   <= 32'd0;
      tout_q  <= 1'b0;
      eot_q   <= 1'b0;
      rdbusy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      pdata_q <= pdata_d;
      rdata_q <= rdata_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      err_q   <= err_d;
      dirty_q <= dirty_d;
      pend_q  <= pend_d;
      slot_q  <= slot_d;
      blk_q   <= blk_d;
      blkw_q  <= blkw_d;
      rew_q   <= rew_d;
      low_q   <= low_d;
      tmr_q   <= tmr_d;
      tout_q  <= tout_d;
      eot_q   <= bus.tape_eot;
      rdbusy_q <= bus.tape_read_busy;
    end
  end

  assign bus.a_ack                  = a_ack_q;
  assign bus.b_ack                  = b_ack_q;
  assign bus.ack_err                = err_q;
  assign bus.rdata                  = rdata_q;
  assign bus.mount_busy             = pend_q;
  assign bus.tape_read              = (state_q == S_ISSUE) && (op_q == 2'd0);
  assign bus.tape_punch             = (state_q == S_ISSUE) && (op_q == 2'd1);
  assign bus.tape_flush             = ((state_q == S_ISSUE) && (op_q == 2'd2)) ||
                                      (state_q == S_M_FLUSH);
  // Registered so the start-block outputs lead the rewind by a cycle.
  assign bus.tape_rewind            = rew_q;
  assign bus.tape_punch_data        = pdata_q;
  assign bus.tape_start_block       = blk_q;
  assign bus.tape_start_block_write = blkw_q;
  assign bus.eot                    = eot_q;
  assign bus.timeout_err            = tout_q;
  assign dbg_state_o                = state_q;
  assign dbg_flags_o                = {dirty_q, pend_q, rr_q, rdbusy_q};
endmodule

// File: tb/tb_tape_port_arbiter.sv
// tb_tape_port_arbiter
//   Table-driven requests plus hand sequences for mount, timeout and reset.
//   Ack words {port(B=1), ack_err, rdata} are queued when a request is driven
//   and compared in order as acks appear.
module tb_tape_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tape_port_if bus();
  logic [2:0] dbg_state;
  logic [3:0] dbg_flags;

  tape_port_arbiter #(.TIMEOUT_CYC(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state),
    .dbg_flags_o(dbg_flags)
  );

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];
  int n_read = 0, n_punch = 0, n_flush = 0, n_rewind = 0, n_acks = 0;
  bit stuck = 1'b0;
  int tcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Tape emulator: drops ready on the negedge after a strobe and raises it
  // three negedges later, unless held stuck.
  always @(negedge clk) begin
    if (reset) begin
      bus.tape_punch_ready = 1'b1;
      tcnt = 0;
    end else begin
      if (bus.tape_read)   n_read++;
      if (bus.tape_punch)  n_punch++;
      if (bus.tape_flush)  n_flush++;
      if (bus.tape_rewind) n_rewind++;
      if (bus.tape_read || bus.tape_punch || bus.tape_flush) begin
        bus.tape_punch_ready = 1'b0;
        tcnt = 3;
      end else if (tcnt > 1) begin
        tcnt--;
      end else if (!stuck) begin
        tcnt = 0;
        bus.tape_punch_ready = 1'b1;
      end
    end
  end

  // Scoreboard
  always @(negedge clk) begin
    if (!reset && (bus.a_ack || bus.b_ack)) begin
      n_acks++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got %0h expected none", {bus.b_ack, bus.ack_err, bus.rdata});
      end else begin
        chk("ack_word", {22'd0, bus.b_ack, bus.ack_err, bus.rdata}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       a_en;
    logic [1:0] a_op;
    logic [7:0] a_wd;
    logic       b_en;
    logic [1:0] b_op;
    logic [7:0] b_wd;
    logic [7:0] tdata;
    int         n_exp;
    logic [9:0] e0;
    logic [9:0] e1;
    int         n_strb;
    int         exp_lat;
  } vec_t;

  task automatic run_vec(input string name, input vec_t v, output int lat);
    int s0;
    int c;
    s0 = n_read + n_punch + n_flush;
    exp_q.push_back(v.e0);
    if (v.n_exp == 2) exp_q.push_back(v.e1);
    bus.tape_read_data = v.tdata;
    bus.a_op = v.a_op;  bus.a_wdata = v.a_wd;
    bus.b_op = v.b_op;  bus.b_wdata = v.b_wd;
    bus.a_req = v.a_en; bus.b_req = v.b_en;
    lat = 0;
    c = 0;
    while ((bus.a_req || bus.b_req) && c < 400) begin
      @(negedge clk);
      c++;
      if (bus.a_ack) begin bus.a_req = 1'b0; if (lat == 0) lat = c; end
      if (bus.b_ack) begin bus.b_req = 1'b0; if (lat == 0) lat = c; end
    end
    if (bus.a_req || bus.b_req) begin
      checks++;
      errors++;
      $display("FAIL %s_no_ack: got no ack after %0d cycles expected ack", name, c);
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk({name, "_strobes"}, n_read + n_punch + n_flush - s0, v.n_strb);
    if (v.exp_lat != 0) chk({name, "_latency"}, lat, v.exp_lat);
  endtask

  task automatic mount_seq(input string name, input logic [3:0] slot, input int exp_flush,
                           input logic [21:0] exp_blk, input logic [21:0] exp_blkw,
                           input int max_cyc);
    int f0, rew_cyc, fl_at_rew;
    logic [21:0] prev_blk, blk_before;
    logic busy1;
    f0 = n_flush;
    rew_cyc = 0; fl_at_rew = 0; busy1 = 1'b0;
    prev_blk = bus.tape_start_block; blk_before = prev_blk;
    bus.mount_slot = slot;
    bus.mount_req = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin bus.mount_req = 1'b0; busy1 = bus.mount_busy; end
      if (bus.tape_rewind && rew_cyc == 0) begin
        rew_cyc = c;
        blk_before = prev_blk;
        fl_at_rew = n_flush - f0;
      end
      prev_blk = bus.tape_start_block;
    end
    chk({name, "_busy"}, busy1, 1);
    chk({name, "_rewind_seen"}, rew_cyc > 0, 1);
    chk({name, "_rewind_in_time"}, rew_cyc <= max_cyc, 1);
    chk({name, "_flush_before_rewind"}, fl_at_rew, exp_flush);
    chk({name, "_start_block"}, bus.tape_start_block, exp_blk);
    chk({name, "_start_block_write"}, bus.tape_start_block_write, exp_blkw);
    chk({name, "_block_lead"}, blk_before, exp_blk);
    chk({name, "_busy_cleared"}, bus.mount_busy, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_a_ack"}, bus.a_ack, 0);
    chk({tag, "_b_ack"}, bus.b_ack, 0);
    chk({tag, "_ack_err"}, bus.ack_err, 0);
    chk({tag, "_strobes"}, {bus.tape_read, bus.tape_punch, bus.tape_flush, bus.tape_rewind}, 0);
    chk({tag, "_mount_busy"}, bus.mount_busy, 0);
    chk({tag, "_eot"}, bus.eot, 0);
    chk({tag, "_timeout_err"}, bus.timeout_err, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
    chk({tag, "_punch_data"}, bus.tape_punch_data, 0);
    chk({tag, "_start_block"}, bus.tape_start_block, 0);
    chk({tag, "_start_block_write"}, bus.tape_start_block_write, 22'd2097152);
    chk({tag, "_state"}, dbg_state, 0);
    chk({tag, "_dirty"}, dbg_flags[3], 0);
  endtask

  vec_t vt[5];
  vec_t vto;
  int lat;
  int acks0;

  initial begin
    //        a_en op  wd     b_en op  wd     tdata  n  e0        e1        strb lat
    vt[0] = '{1'b1, 2'd0, 8'h00, 1'b1, 2'd0, 8'h00, 8'h11, 2, 10'h011, 10'h211, 2, 0};
    vt[1] = '{1'b1, 2'd0, 8'h00, 1'b1, 2'd0, 8'h00, 8'h22, 2, 10'h022, 10'h222, 2, 0};
    vt[2] = '{1'b1, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 8'h5A, 1, 10'h05A, 10'h000, 1, 5};
    vt[3] = '{1'b1, 2'd3, 8'h00, 1'b0, 2'd0, 8'h00, 8'h66, 1, 10'h15A, 10'h000, 0, 1};
    vt[4] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'hC3, 8'h77, 1, 10'h25A, 10'h000, 1, 5};

    reset = 1'b1;
    bus.a_req = 0; bus.b_req = 0; bus.a_op = 0; bus.b_op = 0;
    bus.a_wdata = 0; bus.b_wdata = 0; bus.mount_req = 0; bus.mount_slot = 0;
    bus.tape_read_busy = 0; bus.tape_read_data = 0; bus.tape_eot = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset("por");
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_vec($sformatf("vec%0d", i), vt[i], lat);
    end
    chk("punch_data_held", bus.tape_punch_data, 8'hC3);
    chk("dirty_after_punch", dbg_flags[3], 1);

    mount_seq("mount_dirty", 4'd3, 1, 22'd24576, 22'd2121728, 20);
    chk("dirty_after_mount", dbg_flags[3], 0);
    mount_seq("mount_clean", 4'd5, 0, 22'd40960, 22'd2138112, 3);

    bus.tape_eot = 1'b1;
    repeat (2) @(negedge clk);
    chk("eot_copy", bus.eot, 1);
    bus.tape_eot = 1'b0;
    repeat (2) @(negedge clk);

    stuck = 1'b1;
    vto = '{1'b1, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 8'h99, 1, 10'h15A, 10'h000, 1, 0};
    run_vec("timeout", vto, lat);
    chk("timeout_latency_window", (lat >= 98 && lat <= 106), 1);
    chk("timeout_err_set", bus.timeout_err, 1);
    stuck = 1'b0;
    repeat (5) @(negedge clk);
    chk("timeout_err_sticky", bus.timeout_err, 1);

    bus.tape_read_data = 8'h99;
    bus.a_op = 2'd0;
    bus.a_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("reached_wait_ready", dbg_state, 3);
    reset = 1'b1;
    bus.a_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset("midreset");
    acks0 = n_acks;
    repeat (10) @(negedge clk);
    chk("no_ack_after_reset", n_acks - acks0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
